// File: rtl/amem_seq.sv
// Write/readout sequencer for a circular switched-cap sample array: rolling writes, trigger-frozen
// PRE/POST window, per-cell ADC conversion handshake and valid/ready streaming of the codes.
module amem_seq #(
   parameter int NCELL  = 64,
   parameter int AW     = 6,
   parameter int PRE    = 8,
   parameter int POST   = 16,
   parameter int NREAD  = 32,
   parameter int SETTLE = 3,
   parameter int DW     = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          trig,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic          rd_en,
   output logic [AW-1:0] rd_addr,
   output logic          adc_start,
   input  logic          adc_done,
   input  logic [DW-1:0] adc_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   output logic          busy,
   output logic          trig_miss
);

   localparam int KW = (NREAD > 1) ? $clog2(NREAD) : 1;
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int PW = (POST > 1) ? $clog2(POST) : 1;
   localparam int FW = AW + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SAMPLE,
      S_POST,
      S_RD_SETTLE,
      S_RD_CONV,
      S_RD_OUT
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [FW-1:0]   fill_q, fill_d;
   logic [AW-1:0]   trig_addr_q, trig_addr_d;
   logic [PW-1:0]   post_cnt_q, post_cnt_d;
   logic [SW-1:0]   settle_cnt_q, settle_cnt_d;
   logic [KW-1:0]   k_q, k_d;
   logic [DW-1:0]   out_data_q, out_data_d;
   logic            out_valid_q, out_valid_d;
   logic            out_last_q, out_last_d;
   logic            adc_start_q, adc_start_d;
   logic            trig_miss_q, trig_miss_d;
   logic            trig_ok;
   logic            last_word;
   logic [AW-1:0]   rd_calc;

   // A trigger is only usable once the PRE cells before it hold fresh samples.
   assign trig_ok   = (state_q == S_SAMPLE) && (fill_q >= FW'(PRE));
   assign last_word = (k_q == KW'(NREAD - 1));
   assign rd_calc   = trig_addr_q - AW'(PRE) + AW'(k_q);

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      fill_d       = fill_q;
      trig_addr_d  = trig_addr_q;
      post_cnt_d   = post_cnt_q;
      settle_cnt_d = settle_cnt_q;
      k_d          = k_q;
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;
      out_last_d   = out_last_q;
      adc_start_d  = 1'b0;
      trig_miss_d  = trig && en && !trig_ok;

      case (state_q)
         S_IDLE: begin
            fill_d = '0;
            if (en) state_d = S_SAMPLE;
         end
         S_SAMPLE: begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (fill_q != FW'(NCELL)) fill_d = fill_q + FW'(1);
            if (trig && trig_ok) begin
               trig_addr_d = wr_ptr_q;
               post_cnt_d  = '0;
               state_d     = S_POST;
            end else if (!en) begin
               state_d = S_IDLE;
            end
         end
         S_POST: begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (post_cnt_q == PW'(POST - 1)) begin
               k_d          = '0;
               settle_cnt_d = '0;
               state_d      = S_RD_SETTLE;
            end else begin
               post_cnt_d = post_cnt_q + PW'(1);
            end
         end
         S_RD_SETTLE: begin
            if (settle_cnt_q == SW'(SETTLE - 1)) begin
               adc_start_d = 1'b1;
               state_d     = S_RD_CONV;
            end else begin
               settle_cnt_d = settle_cnt_q + SW'(1);
            end
         end
         S_RD_CONV: begin
            if (adc_done) begin
               out_data_d  = adc_data;
               out_valid_d = 1'b1;
               out_last_d  = last_word;
               state_d     = S_RD_OUT;
            end
         end
         S_RD_OUT: begin
            // Next conversion waits for acceptance so out_data never changes under backpressure.
            if (out_ready) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               if (!last_word) begin
                  k_d          = k_q + KW'(1);
                  settle_cnt_d = '0;
                  state_d      = S_RD_SETTLE;
               end else begin
                  fill_d   = '0;
                  wr_ptr_d = trig_addr_q + AW'(POST + 1);
                  state_d  = en ? S_SAMPLE : S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         wr_ptr_q     <= '0;
         fill_q       <= '0;
         trig_addr_q  <= '0;
         post_cnt_q   <= '0;
         settle_cnt_q <= '0;
         k_q          <= '0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         adc_start_q  <= 1'b0;
         trig_miss_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         fill_q       <= fill_d;
         trig_addr_q  <= trig_addr_d;
         post_cnt_q   <= post_cnt_d;
         settle_cnt_q <= settle_cnt_d;
         k_q          <= k_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         adc_start_q  <= adc_start_d;
         trig_miss_q  <= trig_miss_d;
      end
   end

   assign wr_en     = (state_q == S_SAMPLE) || (state_q == S_POST);
   assign wr_addr   = wr_ptr_q;
   assign rd_en     = (state_q == S_RD_SETTLE) || (state_q == S_RD_CONV);
   assign rd_addr   = rd_en ? rd_calc : '0;
   assign busy      = (state_q == S_POST) || (state_q == S_RD_SETTLE) ||
                      (state_q == S_RD_CONV) || (state_q == S_RD_OUT);
   assign adc_start = adc_start_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign trig_miss = trig_miss_q;

endmodule

// File: tb/tb_amem_seq.sv
// Directed bench for amem_seq: event table (trigger address, read window, re-arm point,
// backpressured word) plus hand-written reset, early-trigger and reset-during-conversion sequences.
module tb_amem_seq;

   localparam int POST   = 16;
   localparam int NREAD  = 32;
   localparam int SETTLE = 3;

   logic        clk = 1'b0;
   logic        rst, en, trig;
   logic        wr_en, rd_en, adc_start, adc_done, out_valid, out_ready, out_last, busy, trig_miss;
   logic [5:0]  wr_addr, rd_addr;
   logic [11:0] adc_data, out_data;

   int checks = 0;
   int errors = 0;

   amem_seq dut (
      .clk(clk), .rst(rst), .en(en), .trig(trig),
      .wr_en(wr_en), .wr_addr(wr_addr), .rd_en(rd_en), .rd_addr(rd_addr),
      .adc_start(adc_start), .adc_done(adc_done), .adc_data(adc_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy), .trig_miss(trig_miss)
   );

   always #10 clk = ~clk;

   // ADC model: answers one cycle after it sees adc_start; code tags the cell address.
   logic       adc_pend = 1'b0;
   logic [5:0] adc_cell = '0;
   always @(negedge clk) begin
      adc_done = 1'b0;
      if (adc_pend) begin
         adc_done = 1'b1;
         adc_data = 12'hA00 | {6'b0, adc_cell};
         adc_pend = 1'b0;
      end
      if (adc_start === 1'b1) begin
         adc_pend = 1'b1;
         adc_cell = rd_addr;
      end
   end

   typedef struct {
      int trig_at;
      int rd_first;
      int wr_last;
      int rearm;
      int bp_word;
   } ev_t;
   ev_t tbl[3];

   task automatic step;
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic run_event(input ev_t e);
      int n;
      int wr_bad;
      int bp_bad;
      int lastw;
      logic [11:0] d0;
      logic        l0;
      n = 0;
      while (!(wr_en === 1'b1 && int'(wr_addr) == e.trig_at) && n < 200) begin
         step;
         n++;
      end
      chk("reach_trig_addr", 32'(n < 200), 1);
      trig = 1'b1;
      step;
      trig = 1'b0;
      wr_bad = 0;
      lastw  = -1;
      for (int i = 1; i <= POST; i++) begin
         if (wr_en !== 1'b1 || int'(wr_addr) != ((e.trig_at + i) % 64) || busy !== 1'b1) wr_bad++;
         lastw = int'(wr_addr);
         step;
      end
      chk("post_window", wr_bad, 0);
      chk("wr_last", lastw, e.wr_last);
      chk("wr_en_after_post", wr_en, 0);
      chk("first_rd_en", rd_en, 1);
      chk("first_rd_addr", rd_addr, e.rd_first);
      n = 0;
      while (adc_start !== 1'b1 && n < 10) begin
         step;
         n++;
      end
      chk("settle_cycles", n, SETTLE);
      for (int k = 0; k < NREAD; k++) begin
         n = 0;
         do begin
            step;
            n++;
         end while (out_valid !== 1'b1 && n < 100);
         chk("word_valid", 32'(n < 100), 1);
         chk($sformatf("word%0d_data", k), out_data, 12'hA00 | ((e.rd_first + k) % 64));
         chk($sformatf("word%0d_last", k), out_last, 32'(k == NREAD - 1));
         if (k == e.bp_word) begin
            out_ready = 1'b0;
            d0 = out_data;
            l0 = out_last;
            bp_bad = 0;
            for (int i = 0; i < 5; i++) begin
               step;
               if (out_valid !== 1'b1 || out_data !== d0 || out_last !== l0 || adc_start !== 1'b0)
                  bp_bad++;
            end
            chk("backpressure_hold", bp_bad, 0);
            out_ready = 1'b1;
         end
      end
      step;
      chk("after_last_valid", out_valid, 0);
      chk("rearm_wr_en", wr_en, 1);
      chk("rearm_wr_addr", wr_addr, e.rearm);
      chk("rearm_busy", busy, 0);
   endtask

   initial begin
      int n;
      int bad;
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int bad;
      tbl[0] = '{trig_at: 20, rd_first: 12, wr_last: 36, rearm: 37, bp_word: 4};
      tbl[1] = '{trig_at: 2,  rd_first: 58, wr_last: 18, rearm: 19, bp_word: -1};
      tbl[2] = '{trig_at: 40, rd_first: 32, wr_last: 56, rearm: 57, bp_word: 31};

      rst = 1'b1; en = 1'b1; trig = 1'b1; out_ready = 1'b1;
      adc_done = 1'b0; adc_data = '0;

      // Reset held with en/trig toggling.
      for (int i = 0; i < 2; i++) begin
         step;
         chk("rst_wr_en", wr_en, 0);
         chk("rst_outs", {rd_en, adc_start, out_valid, out_last, busy, trig_miss}, 0);
         chk("rst_addr_data", {wr_addr, rd_addr, out_data}, 0);
         en = ~en;
         trig = ~trig;
      end
      rst = 1'b0; en = 1'b0; trig = 1'b0;
      step;
      chk("idle_wr_en", wr_en, 0);

      en = 1'b1;
      for (int r = 0; r < 3; r++) run_event(tbl[r]);

      // Early trigger: third write after arming.
      en = 1'b0;
      step;
      chk("disarm_wr_en", wr_en, 0);
      en = 1'b1;
      step;
      step;
      step;
      chk("early_wr_en", wr_en, 1);
      trig = 1'b1;
      step;
      trig = 1'b0;
      chk("early_trig_miss", trig_miss, 1);
      chk("early_still_sample", {wr_en, busy}, 2'b10);
      step;
      chk("early_miss_pulse_end", trig_miss, 0);
      bad = 0;
      for (int i = 0; i < 24; i++) begin
         if (rd_en !== 1'b0 || busy !== 1'b0 || wr_en !== 1'b1) bad++;
         step;
      end
      chk("early_no_read", bad, 0);

      // Reset while a conversion is outstanding.
      trig = 1'b1;
      step;
      trig = 1'b0;
      n = 0;
      while (adc_start !== 1'b1 && n < 60) begin
         step;
         n++;
      end
      chk("reach_adc_start", 32'(n < 60), 1);
      rst = 1'b1;
      en  = 1'b0;
      step;
      rst = 1'b0;
      chk("midrst_outs", {wr_en, rd_en, adc_start, out_valid, out_last, busy, trig_miss}, 0);
      chk("midrst_addr_data", {wr_addr, rd_addr, out_data}, 0);
      step;
      chk("midrst_late_done_valid", out_valid, 0);
      chk("midrst_late_done_data", out_data, 0);
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         step;
         if (wr_en !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) bad++;
      end
      chk("midrst_idle", bad, 0);
      en = 1'b1;
      step;
      chk("midrst_rearm_wr_en", wr_en, 1);
      chk("midrst_rearm_addr", wr_addr, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
